// File: rtl/aurora_link_reset_sequencer.sv
// Purpose: sequences the Aurora 8b10b core RESET / GT_RESET_IN pins and supervises CHANNEL_UP.
// Latency: outputs registered; CHANNEL_UP reaches the FSM 3 cycles after it is sampled.
// Backpressure: none; MANUAL_RESET_REQ is a single-cycle pulse, ignored while a sequence is in flight.
module aurora_link_reset_sequencer #(
    parameter int PRE_CYCLES  = 128,
    parameter int HOLD_CYCLES = 256,
    parameter int POST_CYCLES = 128,
    parameter int UP_TIMEOUT  = 2000000,
    parameter int DROP_FILTER = 16,
    parameter int MAX_RETRY   = 8,
    parameter int CNT_W       = 24
) (
    input  logic        INIT_CLK_IN,
    input  logic        RESET,
    input  logic        CHANNEL_UP,
    input  logic        MANUAL_RESET_REQ,
    output logic        SYS_RESET_OUT,
    output logic        GT_RESET_OUT,
    output logic        LINK_READY,
    output logic        LINK_FAIL,
    output logic [7:0]  RETRY_COUNT,
    output logic [15:0] DROP_COUNT,
    output logic [2:0]  STATE
);

    typedef enum logic [2:0] {
        ST_ASSERT_SYS = 3'd0,
        ST_HOLD       = 3'd1,
        ST_REL_GT     = 3'd2,
        ST_WAIT_UP    = 3'd3,
        ST_LINK_UP    = 3'd4,
        ST_FAIL       = 3'd5
    } state_t;

    // Terminal counts for each timed phase (counter runs 0 .. N-1)
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(UP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_FILTER - 1);

    // CHANNEL_UP synchronizer; deliberately left out of reset
    (* ASYNC_REG = "TRUE" *) logic chup_m1;
    (* ASYNC_REG = "TRUE" *) logic chup_m2;
    (* ASYNC_REG = "TRUE" *) logic chup_s;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   filt;
    logic [CNT_W-1:0]   filt_nxt;
    logic               sys_nxt;
    logic               gt_nxt;
    logic               ready_nxt;
    logic               fail_nxt;
    logic [7:0]         retry_nxt;
    logic [15:0]        drop_nxt;
    logic [7:0]         retry_inc;
    logic [15:0]        drop_inc;
    logic               manual_ok;

    // Bring CHANNEL_UP into the INIT_CLK_IN domain through three flops
    always_ff @(posedge INIT_CLK_IN) begin
        chup_m1 <= CHANNEL_UP;
        chup_m2 <= chup_m1;
        chup_s  <= chup_m2;
    end

    // Saturating increments for the slow-control counters
    assign retry_inc = (RETRY_COUNT == 8'hFF)    ? RETRY_COUNT : RETRY_COUNT + 8'd1;
    assign drop_inc  = (DROP_COUNT  == 16'hFFFF) ? DROP_COUNT  : DROP_COUNT + 16'd1;

    // A manual restart is only honoured once the reset sequence has finished
    assign manual_ok = MANUAL_RESET_REQ &&
                       ((state == ST_WAIT_UP) || (state == ST_LINK_UP) || (state == ST_FAIL));

    // Next-state and next-output logic; manual restart overrides every other event
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        filt_nxt  = '0;
        sys_nxt   = SYS_RESET_OUT;
        gt_nxt    = GT_RESET_OUT;
        ready_nxt = LINK_READY;
        fail_nxt  = LINK_FAIL;
        retry_nxt = RETRY_COUNT;
        drop_nxt  = DROP_COUNT;

        case (state)
            ST_ASSERT_SYS: begin
                sys_nxt   = 1'b1;
                gt_nxt    = 1'b0;
                ready_nxt = 1'b0;
                fail_nxt  = 1'b0;
                if (cnt == PRE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_HOLD;
                    gt_nxt    = 1'b1;
                end
            end
            ST_HOLD: begin
                sys_nxt = 1'b1;
                gt_nxt  = 1'b1;
                if (cnt == HOLD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_REL_GT;
                    gt_nxt    = 1'b0;
                end
            end
            ST_REL_GT: begin
                sys_nxt = 1'b1;
                gt_nxt  = 1'b0;
                if (cnt == POST_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT_UP;
                    sys_nxt   = 1'b0;
                end
            end
            ST_WAIT_UP: begin
                sys_nxt = 1'b0;
                gt_nxt  = 1'b0;
                if (chup_s) begin
                    // Link-up wins over a timeout landing on the same cycle
                    cnt_nxt   = '0;
                    state_nxt = ST_LINK_UP;
                    ready_nxt = 1'b1;
                    retry_nxt = '0;
                end else if (cnt == TO_LAST) begin
                    cnt_nxt   = '0;
                    retry_nxt = retry_inc;
                    sys_nxt   = 1'b1;
                    if ((MAX_RETRY != 0) && (int'(retry_inc) >= MAX_RETRY)) begin
                        state_nxt = ST_FAIL;
                        fail_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_ASSERT_SYS;
                    end
                end
            end
            ST_LINK_UP: begin
                cnt_nxt = '0;
                sys_nxt = 1'b0;
                gt_nxt  = 1'b0;
                if (chup_s) begin
                    filt_nxt = '0;
                end else if (filt == DROP_LAST) begin
                    // Channel has been down long enough to count as a real loss
                    drop_nxt  = drop_inc;
                    ready_nxt = 1'b0;
                    sys_nxt   = 1'b1;
                    state_nxt = ST_ASSERT_SYS;
                end else begin
                    filt_nxt = filt + 1'b1;
                end
            end
            ST_FAIL: begin
                cnt_nxt  = '0;
                sys_nxt  = 1'b1;
                gt_nxt   = 1'b0;
                fail_nxt = 1'b1;
            end
            default: begin
                // Illegal encodings fall back to the start of the sequence
                cnt_nxt   = '0;
                state_nxt = ST_ASSERT_SYS;
                sys_nxt   = 1'b1;
                gt_nxt    = 1'b0;
                ready_nxt = 1'b0;
                fail_nxt  = 1'b0;
            end
        endcase

        if (manual_ok) begin
            state_nxt = ST_ASSERT_SYS;
            cnt_nxt   = '0;
            filt_nxt  = '0;
            sys_nxt   = 1'b1;
            gt_nxt    = 1'b0;
            ready_nxt = 1'b0;
            fail_nxt  = 1'b0;
            retry_nxt = '0;
        end
    end

    // State, counters and registered outputs; RESET parks GT low with SYS high
    always_ff @(posedge INIT_CLK_IN) begin
        if (RESET) begin
            state         <= ST_ASSERT_SYS;
            cnt           <= '0;
            filt          <= '0;
            SYS_RESET_OUT <= 1'b1;
            GT_RESET_OUT  <= 1'b0;
            LINK_READY    <= 1'b0;
            LINK_FAIL     <= 1'b0;
            RETRY_COUNT   <= '0;
            DROP_COUNT    <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            filt          <= filt_nxt;
            SYS_RESET_OUT <= sys_nxt;
            GT_RESET_OUT  <= gt_nxt;
            LINK_READY    <= ready_nxt;
            LINK_FAIL     <= fail_nxt;
            RETRY_COUNT   <= retry_nxt;
            DROP_COUNT    <= drop_nxt;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_aurora_link_reset_sequencer.sv
// Purpose: directed bench for aurora_link_reset_sequencer with a per-cycle reference model.
// Latency: model tracks the 3-cycle CHANNEL_UP delay and registered outputs.
// Backpressure: none; inputs are driven on the falling edge.
module tb_aurora_link_reset_sequencer;

    localparam int PRE  = 4;
    localparam int HOLD = 8;
    localparam int POST = 4;
    localparam int TO   = 50;
    localparam int DROP = 16;
    localparam int MAXR = 3;
    localparam int SEQ_LEN = PRE + HOLD + POST;

    localparam int P_SEQ  = 0;
    localparam int P_WAIT = 1;
    localparam int P_UP   = 2;
    localparam int P_FAIL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        chup;
    logic        man;
    logic        sys_o;
    logic        gt_o;
    logic        rdy_o;
    logic        fail_o;
    logic [7:0]  retry_o;
    logic [15:0] drop_o;
    logic [2:0]  state_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    aurora_link_reset_sequencer #(
        .PRE_CYCLES (PRE),
        .HOLD_CYCLES(HOLD),
        .POST_CYCLES(POST),
        .UP_TIMEOUT (TO),
        .DROP_FILTER(DROP),
        .MAX_RETRY  (MAXR),
        .CNT_W      (24)
    ) dut (
        .INIT_CLK_IN     (clk),
        .RESET           (rst),
        .CHANNEL_UP      (chup),
        .MANUAL_RESET_REQ(man),
        .SYS_RESET_OUT   (sys_o),
        .GT_RESET_OUT    (gt_o),
        .LINK_READY      (rdy_o),
        .LINK_FAIL       (fail_o),
        .RETRY_COUNT     (retry_o),
        .DROP_COUNT      (drop_o),
        .STATE           (state_o)
    );

    always #5 clk = ~clk;

    // Model: the link is in one of four phases; the whole power-on sequence is a
    // single phase measured by elapsed cycles, from which the pins are derived.
    typedef struct {
        int phase;
        int t;
        int w;
        int z;
        int retry;
        int drop;
        bit h0;
        bit h1;
        bit h2;
    } model_t;

    model_t m = '{phase: P_SEQ, t: 0, w: 0, z: 0, retry: 0, drop: 0, h0: 1'b0, h1: 1'b0, h2: 1'b0};

    function automatic model_t restart(model_t c);
        model_t n = c;
        n.phase = P_SEQ;
        n.t = 0;
        n.w = 0;
        n.z = 0;
        return n;
    endfunction

    function automatic model_t step(model_t c, bit r, bit mr, bit cu);
        model_t n = c;
        bit used = c.h2;
        n.h2 = c.h1;
        n.h1 = c.h0;
        n.h0 = cu;
        if (r) begin
            n = restart(n);
            n.retry = 0;
            n.drop = 0;
            return n;
        end
        case (c.phase)
            P_SEQ: begin
                if (c.t == SEQ_LEN - 1) begin
                    n.phase = P_WAIT;
                    n.w = 0;
                end else begin
                    n.t = c.t + 1;
                end
            end
            P_WAIT: begin
                if (mr) begin
                    n = restart(n);
                    n.retry = 0;
                end else if (used) begin
                    n.phase = P_UP;
                    n.z = 0;
                    n.retry = 0;
                end else if (c.w == TO - 1) begin
                    n.retry = (c.retry >= 255) ? 255 : c.retry + 1;
                    if (MAXR != 0 && n.retry >= MAXR) n.phase = P_FAIL;
                    else n = restart(n);
                end else begin
                    n.w = c.w + 1;
                end
            end
            P_UP: begin
                if (mr) begin
                    n = restart(n);
                    n.retry = 0;
                end else if (used) begin
                    n.z = 0;
                end else begin
                    n.z = c.z + 1;
                    if (n.z == DROP) begin
                        n.drop = (c.drop >= 65535) ? 65535 : c.drop + 1;
                        n = restart(n);
                    end
                end
            end
            default: begin
                if (mr) begin
                    n = restart(n);
                    n.retry = 0;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [31:0] expect_out(model_t c);
        logic [2:0] st = 3'd0;
        logic sys = 1'b1;
        logic gt = 1'b0;
        logic rd = 1'b0;
        logic fl = 1'b0;
        case (c.phase)
            P_SEQ: begin
                st = (c.t < PRE) ? 3'd0 : (c.t < PRE + HOLD) ? 3'd1 : 3'd2;
                gt = (c.t >= PRE) && (c.t < PRE + HOLD);
            end
            P_WAIT: begin
                st = 3'd3;
                sys = 1'b0;
            end
            P_UP: begin
                st = 3'd4;
                sys = 1'b0;
                rd = 1'b1;
            end
            default: begin
                st = 3'd5;
                fl = 1'b1;
            end
        endcase
        return {1'b0, st, sys, gt, rd, fl, 8'(c.retry), 16'(c.drop)};
    endfunction

    // Advance the model with exactly what the DUT samples on this edge
    always @(posedge clk) m <= step(m, rst, man, chup);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en)
            check("model_cycle",
                  {1'b0, state_o, sys_o, gt_o, rdy_o, fail_o, retry_o, drop_o},
                  expect_out(m));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_man();
        man = 1'b1;
        tick(1);
        man = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit);
        int n = 0;
        while (state_o !== s && n < limit) begin
            tick(1);
            n++;
        end
        check("wait_state", {29'd0, state_o}, {29'd0, s});
    endtask

    initial begin
        rst  = 1'b1;
        chup = 1'b0;
        man  = 1'b0;
        tick(5);
        cmp_en = 1'b1;

        // Reset values
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_sys",   {31'd0, sys_o},   32'd1);
        check("rst_gt",    {31'd0, gt_o},    32'd0);
        check("rst_cnts",  {8'd0, retry_o, drop_o}, 32'd0);

        // Power-on sequence
        rst = 1'b0;
        tick(3);
        check("pre_gt_low",   {31'd0, gt_o}, 32'd0);
        tick(1);
        check("gt_rise",      {31'd0, gt_o}, 32'd1);
        check("hold_state",   {29'd0, state_o}, 32'd1);
        tick(7);
        check("gt_held",      {31'd0, gt_o}, 32'd1);
        tick(1);
        check("gt_fall",      {31'd0, gt_o}, 32'd0);
        check("relgt_state",  {29'd0, state_o}, 32'd2);
        tick(3);
        check("post_sys_hi",  {31'd0, sys_o}, 32'd1);
        tick(1);
        check("sys_fall",     {31'd0, sys_o}, 32'd0);
        check("wait_state3",  {29'd0, state_o}, 32'd3);

        // Link-up 20 cycles into WAIT_UP
        tick(20);
        chup = 1'b1;
        tick(3);
        check("sync_delay",   {31'd0, rdy_o}, 32'd0);
        tick(1);
        check("link_ready",   {31'd0, rdy_o}, 32'd1);
        check("linkup_state", {29'd0, state_o}, 32'd4);
        check("linkup_retry", {24'd0, retry_o}, 32'd0);

        // Short glitch is filtered
        chup = 1'b0;
        tick(10);
        chup = 1'b1;
        tick(20);
        check("glitch_state", {29'd0, state_o}, 32'd4);
        check("glitch_drop",  {16'd0, drop_o}, 32'd0);
        check("glitch_ready", {31'd0, rdy_o}, 32'd1);

        // Long drop restarts the sequence
        chup = 1'b0;
        tick(30);
        check("drop_count",   {16'd0, drop_o}, 32'd1);
        check("drop_ready",   {31'd0, rdy_o}, 32'd0);
        check("drop_state",   {29'd0, state_o}, 32'd1);

        // Manual request in HOLD is ignored
        pulse_man();
        check("man_hold_ign", {29'd0, state_o}, 32'd2);
        check("man_hold_gt",  {31'd0, gt_o}, 32'd0);

        // Three timeouts lead to FAIL
        wait_state(3'd5, 400);
        check("fail_flag",    {31'd0, fail_o}, 32'd1);
        check("fail_retry",   {24'd0, retry_o}, 32'd3);
        tick(20);
        check("fail_held",    {29'd0, state_o}, 32'd5);
        check("fail_sys",     {30'd0, sys_o, gt_o}, 32'd2);
        pulse_man();
        check("man_fail_st",  {29'd0, state_o}, 32'd0);
        check("man_fail_fl",  {31'd0, fail_o}, 32'd0);
        check("man_fail_rt",  {24'd0, retry_o}, 32'd0);

        // RESET mid-HOLD
        wait_state(3'd1, 20);
        tick(2);
        check("midhold_gt",   {31'd0, gt_o}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_gt",   {31'd0, gt_o}, 32'd0);
        check("rst_mid_sys",  {31'd0, sys_o}, 32'd1);
        check("rst_mid_st",   {29'd0, state_o}, 32'd0);
        check("rst_mid_cnt",  {8'd0, retry_o, drop_o}, 32'd0);

        // One timeout, then link-up on the very timeout cycle
        wait_state(3'd3, 40);
        tick(TO);
        check("to1_state",    {29'd0, state_o}, 32'd0);
        check("to1_retry",    {24'd0, retry_o}, 32'd1);
        wait_state(3'd3, 40);
        tick(TO - 4);
        chup = 1'b1;
        tick(3);
        check("pre_to_state", {29'd0, state_o}, 32'd3);
        tick(1);
        check("to_up_state",  {29'd0, state_o}, 32'd4);
        check("to_up_retry",  {24'd0, retry_o}, 32'd0);

        // Manual request on the same cycle as synchronized link-up
        chup = 1'b0;
        pulse_man();
        check("man_up_state", {29'd0, state_o}, 32'd0);
        wait_state(3'd3, 40);
        chup = 1'b1;
        tick(3);
        man = 1'b1;
        tick(1);
        man = 1'b0;
        check("man_vs_up_st", {29'd0, state_o}, 32'd0);
        check("man_vs_up_rd", {31'd0, rdy_o}, 32'd0);
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
